mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : I-cache / D-cache / shared-memory bundle for mem_arbiter.
// Rev 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    logic         i_read;
    logic         i_write;
    logic [27:0]  i_addr;
    logic [127:0] i_wdata;
    logic [127:0] i_rdata;
    logic         i_ready;

    logic         d_read;
    logic         d_write;
    logic [27:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_ready;

    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    logic         grant_d;

    // Arbiter side
    modport master (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output grant_d
    );

    // Caches + memory side
    modport slave (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  grant_d
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-cache (I/D) arbiter onto one slow memory port.
// Optional macro MEM_ARB_RR_EN: round-robin on collisions (default: D wins).
// Rev 1.0 - initial release
// ============================================================================
module mem_arbiter (
    input  logic          clk,
    input  logic          proc_reset,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [27:0]   r_mem_addr;
    logic [127:0]  r_mem_wdata;
    logic          r_grant_d;

    logic          w_i_pend;
    logic          w_d_pend;
    logic          w_pick_d;

    assign w_i_pend = bus.i_read | bus.i_write;
    assign w_d_pend = bus.d_read | bus.d_write;

`ifdef MEM_ARB_RR_EN
    logic          r_last_d;
    // On a collision the requester that was not served last wins.
    assign w_pick_d = w_d_pend & (~w_i_pend | ~r_last_d);
`else
    assign w_pick_d = w_d_pend;
`endif

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_grant_d   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_d    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_state     <= SERVE_D;
                        r_grant_d   <= 1'b1;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                        // A simultaneous read+write is issued as a write only.
                        r_mem_write <= bus.d_write;
                        r_mem_read  <= bus.d_read & ~bus.d_write;
`ifdef MEM_ARB_RR_EN
                        r_last_d    <= 1'b1;
`endif
                    end else if (w_i_pend) begin
                        r_state     <= SERVE_I;
                        r_grant_d   <= 1'b0;
                        r_mem_addr  <= bus.i_addr;
                        r_mem_wdata <= bus.i_wdata;
                        r_mem_write <= bus.i_write;
                        r_mem_read  <= bus.i_read & ~bus.i_write;
`ifdef MEM_ARB_RR_EN
                        r_last_d    <= 1'b0;
`endif
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.mem_ready) begin
                        r_state     <= DONE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_grant_d   <= 1'b0;
                    end
                end
                // One dead cycle so the served cache can drop its request.
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_grant_d   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.grant_d   = r_grant_d;

    assign bus.i_ready   = bus.mem_ready & (r_state == SERVE_I);
    assign bus.d_ready   = bus.mem_ready & (r_state == SERVE_D);
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : vector table, collision sequence and randomized run
// against a transaction-level owner/gap model of the arbiter.
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic proc_reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [127:0] IW  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] AWD = {16{8'hA5}};

    typedef struct {
        logic        rst, ir, iw;
        logic [27:0] ia;
        logic        dr, dw;
        logic [27:0] da;
        logic        mrdy;
        logic        e_rd, e_wr;
        logic [27:0] e_addr;
        logic [127:0] e_wd;
        logic        e_gd, e_iy, e_dy;
    } vec_t;

    function automatic vec_t mk(input logic rst, ir, iw, input logic [27:0] ia,
                                input logic dr, dw, input logic [27:0] da, input logic mrdy,
                                input logic e_rd, e_wr, input logic [27:0] e_addr,
                                input logic [127:0] e_wd, input logic e_gd, e_iy, e_dy);
        vec_t v;
        v.rst = rst; v.ir = ir; v.iw = iw; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
        v.mrdy = mrdy; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_gd = e_gd; v.e_iy = e_iy; v.e_dy = e_dy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, ir, iw, input logic [27:0] ia,
                         input logic dr, dw, input logic [27:0] da, input logic mrdy);
        proc_reset    = rst;
        bus.i_read    = ir;
        bus.i_write   = iw;
        bus.i_addr    = ia;
        bus.d_read    = dr;
        bus.d_write   = dw;
        bus.d_addr    = da;
        bus.mem_ready = mrdy;
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic check_all(input string tag, input logic e_rd, e_wr, input logic [27:0] e_addr,
                             input logic [127:0] e_wd, input logic e_gd, e_iy, e_dy);
        chk({tag, ".mem_read"},  bus.mem_read,  e_rd);
        chk({tag, ".mem_write"}, bus.mem_write, e_wr);
        chk({tag, ".mem_addr"},  bus.mem_addr,  e_addr);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, e_wd);
        chk({tag, ".grant_d"},   bus.grant_d,   e_gd);
        chk({tag, ".i_ready"},   bus.i_ready,   e_iy);
        chk({tag, ".d_ready"},   bus.d_ready,   e_dy);
        chk({tag, ".i_rdata"},   bus.i_rdata,   bus.mem_rdata);
        chk({tag, ".d_rdata"},   bus.d_rdata,   bus.mem_rdata);
    endtask

    // Reference model: who owns memory, whether we sit in the post-transfer gap,
    // and the request captured at grant time.
    int           m_owner = 0;   // 0 none, 1 I-cache, 2 D-cache
    bit           m_gap   = 1'b0;
    logic         m_rd = 1'b0, m_wr = 1'b0, m_last_d = 1'b0;
    logic [27:0]  m_addr = '0;
    logic [127:0] m_wd   = '0;

    task automatic model_step();
        bit ip, dp, take_d;
        if (proc_reset) begin
            m_owner = 0; m_gap = 0; m_rd = 0; m_wr = 0;
            m_addr = '0; m_wd = '0; m_last_d = 0;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (m_owner != 0) begin
            if (bus.mem_ready) begin
                m_owner = 0; m_gap = 1; m_rd = 0; m_wr = 0;
            end
        end else begin
            ip = bus.i_read | bus.i_write;
            dp = bus.d_read | bus.d_write;
            if (ip || dp) begin
                if (ip && dp) take_d = RR ? !m_last_d : 1'b1;
                else          take_d = dp;
                m_owner  = take_d ? 2 : 1;
                m_last_d = take_d;
                m_addr   = take_d ? bus.d_addr  : bus.i_addr;
                m_wd     = take_d ? bus.d_wdata : bus.i_wdata;
                m_wr     = take_d ? bus.d_write : bus.i_write;
                m_rd     = (take_d ? bus.d_read : bus.i_read) & !m_wr;
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        drive(1'b1, 0, 0, '0, 0, 0, '0, 0);
        bus.i_wdata = IW;
        bus.d_wdata = AWD;

        //        rst ir iw ia      dr dw da      rdy | rd wr addr    wd   gd iy dy
        vecs.push_back(mk(0,0,0,28'h0, 0,0,28'h0, 0,  0,0,28'h0, '0,  0,0,0));
        vecs.push_back(mk(0,1,0,28'h40,0,0,28'h0, 0,  0,0,28'h0, '0,  0,0,0));
        vecs.push_back(mk(0,1,0,28'h40,0,0,28'h0, 0,  1,0,28'h40,IW,  0,0,0));
        vecs.push_back(mk(0,1,0,28'h40,0,0,28'h0, 0,  1,0,28'h40,IW,  0,0,0));
        vecs.push_back(mk(0,1,0,28'h40,0,0,28'h0, 1,  1,0,28'h40,IW,  0,1,0));
        vecs.push_back(mk(0,0,0,28'h0, 0,0,28'h0, 0,  0,0,28'h40,IW,  0,0,0));
        vecs.push_back(mk(0,0,0,28'h0, 0,0,28'h0, 0,  0,0,28'h40,IW,  0,0,0));
        vecs.push_back(mk(0,1,0,28'h80,0,1,28'h10,0,  0,0,28'h40,IW,  0,0,0));
        vecs.push_back(mk(0,1,0,28'h80,0,1,28'h10,0,  0,1,28'h10,AWD, 1,0,0));
        vecs.push_back(mk(0,1,0,28'h80,0,1,28'h20,0,  0,1,28'h10,AWD, 1,0,0));
        vecs.push_back(mk(0,1,0,28'h80,0,1,28'h20,1,  0,1,28'h10,AWD, 1,0,1));
        vecs.push_back(mk(0,1,0,28'h80,0,0,28'h20,0,  0,0,28'h10,AWD, 0,0,0));
        vecs.push_back(mk(0,1,0,28'h80,0,0,28'h20,0,  0,0,28'h10,AWD, 0,0,0));
        vecs.push_back(mk(0,1,0,28'h80,0,0,28'h20,0,  1,0,28'h80,IW,  0,0,0));
        vecs.push_back(mk(0,1,0,28'h80,0,0,28'h20,1,  1,0,28'h80,IW,  0,1,0));
        vecs.push_back(mk(0,1,0,28'h80,1,1,28'h30,0,  0,0,28'h80,IW,  0,0,0));
        vecs.push_back(mk(0,1,0,28'h80,1,1,28'h30,0,  0,0,28'h80,IW,  0,0,0));
        vecs.push_back(mk(0,1,0,28'h80,1,1,28'h30,0,  0,1,28'h30,AWD, 1,0,0));
        vecs.push_back(mk(0,1,0,28'h80,1,1,28'h30,1,  0,1,28'h30,AWD, 1,0,1));
        vecs.push_back(mk(0,0,0,28'h0, 0,0,28'h0, 0,  0,0,28'h30,AWD, 0,0,0));
        vecs.push_back(mk(0,0,0,28'h0, 0,0,28'h0, 1,  0,0,28'h30,AWD, 0,0,0));
        vecs.push_back(mk(0,1,0,28'h50,0,0,28'h0, 0,  0,0,28'h30,AWD, 0,0,0));
        vecs.push_back(mk(0,1,0,28'h50,0,0,28'h0, 0,  1,0,28'h50,IW,  0,0,0));
        vecs.push_back(mk(1,1,0,28'h50,0,0,28'h0, 0,  1,0,28'h50,IW,  0,0,0));
        vecs.push_back(mk(0,0,0,28'h0, 0,0,28'h0, 1,  0,0,28'h0, '0,  0,0,0));
        vecs.push_back(mk(0,0,0,28'h0, 0,0,28'h0, 0,  0,0,28'h0, '0,  0,0,0));

        repeat (2) @(posedge clk);
        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk); #2;
            drive(vecs[k].rst, vecs[k].ir, vecs[k].iw, vecs[k].ia,
                  vecs[k].dr, vecs[k].dw, vecs[k].da, vecs[k].mrdy);
            @(negedge clk);
            check_all($sformatf("vec%0d", k), vecs[k].e_rd, vecs[k].e_wr, vecs[k].e_addr,
                      vecs[k].e_wd, vecs[k].e_gd, vecs[k].e_iy, vecs[k].e_dy);
        end

        // Collision right after a lone D service: RR hands it to I, fixed priority to D.
        @(posedge clk); #2; drive(0, 0,0,28'h0,  1,0,28'h60, 0);
        @(posedge clk); #2; drive(0, 0,0,28'h0,  1,0,28'h60, 0);
        @(negedge clk);
        chk("rr.first_grant_d", bus.grant_d, 1'b1);
        chk("rr.first_addr", bus.mem_addr, 28'h60);
        @(posedge clk); #2; drive(0, 0,0,28'h0,  1,0,28'h60, 1);
        @(negedge clk);
        chk("rr.first_d_ready", bus.d_ready, 1'b1);
        @(posedge clk); #2; drive(0, 1,0,28'h90, 1,0,28'h70, 0);
        @(posedge clk); #2; drive(0, 1,0,28'h90, 1,0,28'h70, 0);
        @(negedge clk);
        chk("rr.gap_grant_d", bus.grant_d, 1'b0);
        chk("rr.gap_read", bus.mem_read, 1'b0);
        @(posedge clk); #2; drive(0, 1,0,28'h90, 1,0,28'h70, 0);
        @(negedge clk);
        chk("rr.coll_grant_d", bus.grant_d, !RR);
        chk("rr.coll_addr", bus.mem_addr, RR ? 28'h90 : 28'h70);
        chk("rr.coll_wdata", bus.mem_wdata, RR ? IW : AWD);
        chk("rr.coll_read", bus.mem_read, 1'b1);
        @(posedge clk); #2; drive(0, 1,0,28'h90, 1,0,28'h70, 1);
        @(negedge clk);
        chk("rr.coll_i_ready", bus.i_ready, RR);
        chk("rr.coll_d_ready", bus.d_ready, !RR);
        @(posedge clk); #2; drive(1, 0,0,28'h0, 0,0,28'h0, 0);

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step();
            #2;
            drive((c != 0) && ($urandom_range(0, 199) == 0),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, 28'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, 28'($urandom),
                  $urandom_range(0, 2) == 0);
            bus.i_wdata = {$urandom, $urandom, $urandom, $urandom};
            bus.d_wdata = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check_all($sformatf("rnd%0d", c), m_rd, m_wr, m_addr, m_wd,
                      m_owner == 2,
                      bus.mem_ready && (m_owner == 1),
                      bus.mem_ready && (m_owner == 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
